// File: rtl/icache_pkg.sv
// Shared types, constants and address helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_MISS,
      ST_REFILL,
      ST_RESP
   } state_t;

   localparam logic [2:0] RD_TYPE_LINE = 3'b100;
   localparam logic [2:0] RD_TYPE_WORD = 3'b010;

   // 16-byte line: 4 words, byte offset [3:0]
   localparam int OFFSET_W = 4;

   function automatic int tag_width(input int index_w);
      return 32 - index_w - OFFSET_W;
   endfunction

   function automatic int index_width(input int index_w);
      return index_w;
   endfunction

   // kseg1 (0xA000_0000 - 0xBFFF_FFFF) is fetched uncached
   function automatic logic is_uncached(input logic [31:0] addr);
      return addr[31:29] == 3'b101;
   endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Tag, data and valid storage with one synchronous read port and two write ports.
module icache_line_ram
   import icache_pkg::*;
#(
   parameter int INDEX_W = 8,
   parameter int TAG_W   = tag_width(INDEX_W)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               rd_en,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [3:0][31:0]   rd_line,
   input  logic               data_we,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [1:0]         wr_word,
   input  logic [31:0]        wr_data,
   input  logic               tag_we,
   input  logic [TAG_W-1:0]   wr_tag
);

   localparam int LINES = 1 << INDEX_W;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [3:0][31:0]  data_mem [LINES];
   logic [LINES-1:0]  valid_q;

   // Valid bits: all cleared on reset, one set when a line refill completes.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q <= '0;
      end else if (tag_we) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and per-word data writes.
   // NOTE: the arrays carry no reset; valid_q alone decides whether an entry means anything.
   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[wr_idx] <= wr_tag;
      end
      if (data_we) begin
         data_mem[wr_idx][wr_word] <= wr_data;
      end
   end

   // Registered valid read for the index being accepted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_valid <= 1'b0;
      end else if (rd_en) begin
         rd_valid <= valid_q[rd_idx];
      end
   end

   // Registered tag/line read for the index being accepted.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_tag  <= tag_mem[rd_idx];
         rd_line <= data_mem[rd_idx];
      end
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 4-word line refill and kseg1 bypass.
module icache_dm
   import icache_pkg::*;
#(
   parameter int INDEX_W = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic        cpu_addr_ok,
   output logic        cpu_data_ok,
   output logic [31:0] cpu_rdata,
   output logic        inst_rd_req,
   output logic [2:0]  inst_rd_type,
   output logic [31:0] inst_rd_addr,
   input  logic        inst_rd_rdy,
   input  logic        inst_ret_valid,
   input  logic [1:0]  inst_ret_last,
   input  logic [31:0] inst_ret_data
);

   localparam int TAG_W   = tag_width(INDEX_W);
   localparam int TAG_LSB = OFFSET_W + index_width(INDEX_W);

   state_t             state_q, state_d;
   logic [31:0]        addr_q;
   logic [1:0]         cnt_q;
   logic [31:0]        resp_q;

   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [3:0][31:0]   rd_line;

   logic [INDEX_W-1:0] idx_q;
   logic [TAG_W-1:0]   tag_q;
   logic               uncached_q;
   logic               hit;
   logic               accept;
   logic               ret_fire;
   logic               unused_bits;

   assign idx_q       = addr_q[TAG_LSB-1:OFFSET_W];
   assign tag_q       = addr_q[31:TAG_LSB];
   assign uncached_q  = is_uncached(addr_q);
   assign hit         = (state_q == ST_LOOKUP) && rd_valid && (rd_tag == tag_q) && !uncached_q;
   assign accept      = cpu_req && cpu_addr_ok;
   assign ret_fire    = (state_q == ST_REFILL) && inst_ret_valid;
   assign unused_bits = ^{inst_ret_last[1], addr_q[1:0]};

   icache_line_ram #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_line_ram (
      .clk      (clk),
      .resetn   (resetn),
      .rd_en    (accept),
      .rd_idx   (cpu_addr[TAG_LSB-1:OFFSET_W]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .data_we  (ret_fire && !uncached_q),
      .wr_idx   (idx_q),
      .wr_word  (cnt_q),
      .wr_data  (inst_ret_data),
      .tag_we   (ret_fire && !uncached_q && inst_ret_last[0]),
      .wr_tag   (tag_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (accept) state_d = ST_LOOKUP;
         ST_LOOKUP: begin
            if (!hit)         state_d = ST_MISS;
            else if (!accept) state_d = ST_IDLE;
         end
         ST_MISS:   if (inst_rd_rdy) state_d = ST_REFILL;
         ST_REFILL: if (ret_fire && (uncached_q || inst_ret_last[0])) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Handshake and bridge outputs decoded from the current state.
   always_comb begin
      cpu_addr_ok  = 1'b0;
      cpu_data_ok  = 1'b0;
      cpu_rdata    = '0;
      inst_rd_req  = 1'b0;
      inst_rd_type = '0;
      inst_rd_addr = '0;
      unique case (state_q)
         ST_IDLE:   cpu_addr_ok = 1'b1;
         ST_LOOKUP: begin
            if (hit) begin
               cpu_addr_ok = 1'b1;
               cpu_data_ok = 1'b1;
               cpu_rdata   = rd_line[addr_q[3:2]];
            end
         end
         ST_MISS: begin
            inst_rd_req  = 1'b1;
            inst_rd_type = uncached_q ? RD_TYPE_WORD : RD_TYPE_LINE;
            inst_rd_addr = uncached_q ? {addr_q[31:2], 2'b00} : {addr_q[31:OFFSET_W], 4'h0};
         end
         ST_RESP: begin
            cpu_data_ok = 1'b1;
            cpu_rdata   = resp_q;
         end
         default: ;
      endcase
   end

   // Request address, refill word counter and response buffer.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q <= '0;
         cnt_q  <= '0;
         resp_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= cpu_addr;
         end
         if ((state_q == ST_MISS) && inst_rd_rdy) begin
            cnt_q <= '0;
         end else if (ret_fire && !uncached_q) begin
            cnt_q <= cnt_q + 2'd1;
         end
         if (ret_fire && (uncached_q || (cnt_q == addr_q[3:2]))) begin
            resp_q <= inst_ret_data;
         end
      end
   end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the CPU fetch stage and the cache-to-AXI bridge's instruction read port. It accepts one fetch at a time over an SRAM-like req/addr_ok/data_ok handshake and returns hits one cycle after acceptance. Misses are refilled as 4-word lines via `inst_rd_*`/`inst_ret_*`. Addresses in kseg1 (0xA000_0000–0xBFFF_FFFF) bypass the cache as single-word reads with no allocation.

## Interface
- `INDEX_W`, default 8: index bits, giving 2^INDEX_W lines. Line is 16 B (4 × 32-bit), offset [3:0], index [INDEX_W+3:4], tag [31:INDEX_W+4].
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `cpu_req` in 1: fetch request.
- `cpu_addr` in 32: byte address; [1:0] ignored.
- `cpu_addr_ok` out 1: request accepted this cycle (req && addr_ok).
- `cpu_data_ok` out 1: `cpu_rdata` valid, one-cycle pulse.
- `cpu_rdata` out 32: fetched word.
- `inst_rd_req` out 1: refill request to bridge.
- `inst_rd_type` out 3: 3'b100 for a line, 3'b010 for an uncached word.
- `inst_rd_addr` out 32: {tag,index,4'b0} for a line; the exact word address for uncached.
- `inst_rd_rdy` in 1: bridge accepted `inst_rd_req`.
- `inst_ret_valid` in 1: return word valid.
- `inst_ret_last` in 2: bit 0 marks the final return word; bit 1 is ignored.
- `inst_ret_data` in 32: return word.

## Operation
- **Storage:** 2^INDEX_W tag entries (tag width 20 at default), 2^INDEX_W valid flops, and 4-word data lines. Tag and data arrays are read synchronously using the index of the address being accepted.
- **States:** IDLE, LOOKUP, MISS, REFILL, RESP.
- **IDLE:**
  - `cpu_addr_ok` = 1.
  - On accept: register the address, start the array read, go to LOOKUP.
- **LOOKUP:**
  - Hit = valid[idx] && tag[idx]==addr_tag && !uncached.
  - On hit: `cpu_data_ok`=1 and `cpu_rdata`=line word [3:2]. `cpu_addr_ok`=1 in the same cycle; if a new request is accepted, stay in LOOKUP, otherwise go to IDLE.
  - On miss or uncached: `cpu_addr_ok`=0, go to MISS.
- **MISS:**
  - Hold `inst_rd_req`=1 with stable type and address.
  - On `inst_rd_rdy`: clear the word counter, go to REFILL.
- **REFILL (cached):**
  - Each `inst_ret_valid` writes data[idx][cnt] and increments the 2-bit counter.
  - When cnt==addr[3:2], also capture the word into the response buffer.
  - On `inst_ret_valid && inst_ret_last[0]`: write tag[idx] and set valid[idx]=1, go to RESP.
- **REFILL (uncached):**
  - The single return word goes to the response buffer; go to RESP. No arrays are written.
- **RESP:**
  - `cpu_data_ok`=1 with the buffered word, go to IDLE.
- **Ignored inputs:** `inst_ret_valid` outside REFILL is ignored. `inst_rd_rdy` outside MISS is ignored.
- **Refill to a valid line:** the old line is overwritten; no writeback is needed (read-only cache).
- **Outstanding requests:** at most one. `cpu_addr_ok`=0 in MISS, REFILL and RESP.

## Timing
- **Reset values:** state=IDLE, all valid bits 0, counter 0. Outputs after reset: `cpu_addr_ok`=1, `cpu_data_ok`=0, `cpu_rdata`=0, `inst_rd_req`=0, `inst_rd_type`=0, `inst_rd_addr`=0.
- **Hit latency:** accepted at cycle N, `cpu_data_ok` at N+1. Back-to-back hits sustain 1 word/cycle.
- **Miss latency:**
  - Accepted at N, LOOKUP at N+1, `inst_rd_req` from N+2 until `inst_rd_rdy`.
  - If the last return word arrives in cycle L, `cpu_data_ok` is at L+1.
  - The array update happens at the end of L, so a request accepted at L+2 or later hits.
- **Reset mid-refill:** return to IDLE and clear all valid bits; the partial line is never marked valid. The bridge is reset by the same `resetn`.
- **Data stability:** `cpu_rdata` is only defined while `cpu_data_ok`=1.

## Structure
- `icache_pkg` holds:
  - the state enum;
  - `RD_TYPE_LINE`=3'b100 and `RD_TYPE_WORD`=3'b010;
  - the OFFSET_W=4 constant;
  - tag/index width functions of `INDEX_W`;
  - the kseg1 uncached decode function (addr[31:29]==3'b101).
- One sub-module, `icache_line_ram`: tag, data and valid storage with a synchronous read port, a per-word data write and a tag+valid write, plus a reset clear of the valid bits.

## Test plan
- **Cold miss:** fetch 0x8000_0014 after reset, bridge returns 0x11,0x22,0x33,0x44 with last on 0x44. Required: `inst_rd_req` with type 3'b100 and addr 0x8000_0010; then `cpu_data_ok` with 0x22 one cycle after the last word.
- **Hit stream:** fetch 0x8000_0010, 0x18, 0x1C back-to-back. Required: `cpu_data_ok` every cycle with 0x11, 0x33, 0x44, and no `inst_rd_req`.
- **Conflict:** fetch 0x8000_1014, which has the same index 0x01 and a different tag. Required: a line refill from 0x8000_1010. A subsequent fetch of 0x8000_0014 misses again.
- **Uncached:** fetch 0xBFC0_0008, bridge returns 0xDEAD_BEEF with last. Required: type 3'b010, addr 0xBFC0_0008, data 0xDEAD_BEEF. Repeating the fetch issues another `inst_rd_req`.
- **Stalled bridge:** hold `inst_rd_rdy`=0 for 5 cycles. Required: `inst_rd_req`, type and addr stay stable, and `cpu_addr_ok` stays 0.
- **Reset mid-refill:** pull `resetn` low after 2 of the 4 words. Required: state IDLE, all outputs at reset values, and a fetch of that line misses.
